// File: rtl/snes_pad_reader.sv
// SNES controller frame reader: latches the pad, shifts 16 bits out on pad_clk,
// and publishes debounced, sanitised button levels once per accepted frame.
module snes_pad_reader #(
    parameter int HALF_CYC = 390
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic pad_data,
    output logic pad_latch,
    output logic pad_clk,
    output logic left,
    output logic right,
    output logic up,
    output logic down,
    output logic chop,
    output logic carry,
    output logic valid,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        HIGH,
        LOW,
        DONE
    } state_t;

    localparam logic [15:0] LAST = 16'(HALF_CYC - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] shift_q, shift_d;
    logic        sync1_q, sync2_q;
    logic [5:0]  hist_q, hist_d;
    logic [5:0]  btn_q, btn_d;
    logic        valid_q, valid_d;
    logic        latch_q, latch_d;
    logic        pclk_q, pclk_d;
    logic        busy_q, busy_d;

    logic        phase_end;
    logic        disconnected;
    logic        b_up, b_down, b_left, b_right;
    logic [5:0]  cur_btn;
    logic        unused_bits;

    // Per button: adopt the new value only when this frame and the previous
    // accepted frame agree on it; otherwise hold the published level.
    function automatic logic [5:0] debounce(input logic [5:0] cur,
                                            input logic [5:0] hist,
                                            input logic [5:0] out);
        logic [5:0] agree;
        agree    = ~(cur ^ hist);
        debounce = (agree & cur) | (~agree & out);
    endfunction

    assign phase_end    = (cnt_q == LAST);
    assign disconnected = |shift_q[15:12];
    assign unused_bits  = ^{shift_q[11:9], shift_q[3:1]};

    assign b_up    = shift_q[4];
    assign b_down  = shift_q[5];
    assign b_left  = shift_q[6];
    assign b_right = shift_q[7];

    // Opposing directions cancel so the movement logic never sees both.
    assign cur_btn = {b_left & ~b_right, b_right & ~b_left,
                      b_up & ~b_down, b_down & ~b_up,
                      shift_q[8], shift_q[0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        hist_d  = hist_q;
        btn_d   = btn_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            LATCH: begin
                // Two half periods counted as two passes of the 16-bit counter,
                // using idx bit 0 to mark the second pass.
                if (phase_end) begin
                    cnt_d = '0;
                    if (!idx_q[0]) begin
                        idx_d = 4'd1;
                    end else begin
                        idx_d   = '0;
                        state_d = HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = ~sync2_q;
                    state_d        = LOW;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            LOW: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                        if (!disconnected) begin
                            valid_d = 1'b1;
                            btn_d   = debounce(cur_btn, hist_q, btn_q);
                            hist_d  = cur_btn;
                        end
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        latch_d = (state_d == LATCH);
        pclk_d  = (state_d != LOW);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= '0;
            btn_q   <= '0;
            valid_q <= 1'b0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            sync1_q <= pad_data;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            btn_q   <= btn_d;
            valid_q <= valid_d;
            latch_q <= latch_d;
            pclk_q  <= pclk_d;
            busy_q  <= busy_d;
        end
    end

    assign pad_latch = latch_q;
    assign pad_clk   = pclk_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign {left, right, up, down, chop, carry} = btn_q;

endmodule

// File: tb/tb_snes_pad_reader.sv
// Bench for snes_pad_reader: table of frames, hand-written corner sequences,
// and random frames checked against a frame-level reference model.
module tb_snes_pad_reader;

    localparam int H     = 4;
    localparam int FRAME = 34 * H + 2;

    logic clk = 1'b0;
    logic reset, start, pad_data;
    logic pad_latch, pad_clk, left, right, up, down, chop, carry, valid, busy;
    logic [5:0] btn;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    snes_pad_reader #(.HALF_CYC(H)) dut (
        .clk(clk), .reset(reset), .start(start), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk),
        .left(left), .right(right), .up(up), .down(down),
        .chop(chop), .carry(carry), .valid(valid), .busy(busy)
    );

    assign btn = {left, right, up, down, chop, carry};

    // Controller model: latch presents bit 0, each pad_clk rise advances one bit.
    logic [15:0] ctrl_pat = 16'h0000;
    int k = 16;
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) k = 0;
        else           k = k + 1;
    end
    assign pad_data = (k < 16) ? ~ctrl_pat[k[3:0]] : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: works on whole frames (pattern word, 1 = pressed).
    logic [5:0] m_hist, m_out;

    function automatic logic [5:0] model_buttons(input logic [15:0] p);
        logic l, r, u, d;
        l = p[6]; r = p[7]; u = p[4]; d = p[5];
        if (l && r) begin l = 1'b0; r = 1'b0; end
        if (u && d) begin u = 1'b0; d = 1'b0; end
        return {l, r, u, d, p[8], p[0]};
    endfunction

    task automatic model_frame(input logic [15:0] p, output logic exp_v);
        logic [5:0] cur;
        if (p[15:12] != 4'h0) begin
            exp_v = 1'b0;
        end else begin
            cur = model_buttons(p);
            for (int i = 0; i < 6; i++)
                if (cur[i] == m_hist[i]) m_out[i] = cur[i];
            m_hist = cur;
            exp_v  = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called right after pulse_start; returns the inclusive cycle number of valid, or -1.
    task automatic wait_valid(output int n_at);
        n_at = -1;
        for (int n = 2; n <= FRAME + 20; n++) begin
            if (valid) begin
                n_at = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input logic [15:0] p, input bit extra, input logic exp_v,
                             input logic [5:0] exp_btn, input string tag);
        int vcount, vcyc, latch_cyc, lows, badlen, runlen, illegal;
        logic [5:0] prev_btn;
        ctrl_pat = p;
        pulse_start();
        vcount = 0; vcyc = -1; latch_cyc = 0; lows = 0; badlen = 0; runlen = 0; illegal = 0;
        prev_btn = btn;
        for (int n = 2; n <= FRAME + 6; n++) begin
            if (valid) begin vcount++; vcyc = n; end
            if (pad_latch) latch_cyc++;
            if (!pad_clk) begin
                runlen++;
            end else if (runlen > 0) begin
                lows++;
                if (runlen != H) badlen++;
                runlen = 0;
            end
            if (btn !== prev_btn && !valid) illegal++;
            prev_btn = btn;
            if (extra && (n == 10 || n == 100)) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, " valid pulses"}, vcount, {31'd0, exp_v});
        if (exp_v) check({tag, " latency"}, vcyc, FRAME);
        check({tag, " latch cycles"}, latch_cyc, 2 * H);
        check({tag, " pad_clk low pulses"}, lows, 16);
        check({tag, " bad low lengths"}, badlen, 0);
        check({tag, " change outside DONE"}, illegal, 0);
        check({tag, " buttons"}, btn, exp_btn);
        check({tag, " busy after frame"}, busy, 0);
    endtask

    typedef struct {
        logic [15:0] pat;
        bit          extra;
        logic        v;
        logic [5:0]  btn;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int n_at, rises, vseen;
        logic prev_clk, ev;
        logic [15:0] p, prev_p;

        tbl[0]  = '{16'hFFFF, 1'b0, 1'b0, 6'b000000};
        tbl[1]  = '{16'h0000, 1'b0, 1'b1, 6'b000000};
        tbl[2]  = '{16'h0100, 1'b1, 1'b1, 6'b000000};
        tbl[3]  = '{16'h0100, 1'b0, 1'b1, 6'b000010};
        tbl[4]  = '{16'h0030, 1'b0, 1'b1, 6'b000010};
        tbl[5]  = '{16'h0030, 1'b0, 1'b1, 6'b000000};
        tbl[6]  = '{16'h0040, 1'b0, 1'b1, 6'b000000};
        tbl[7]  = '{16'h0040, 1'b1, 1'b1, 6'b100000};
        tbl[8]  = '{16'hFFFF, 1'b0, 1'b0, 6'b100000};
        tbl[9]  = '{16'h0000, 1'b0, 1'b1, 6'b100000};
        tbl[10] = '{16'h0001, 1'b0, 1'b1, 6'b000000};
        tbl[11] = '{16'h0000, 1'b0, 1'b1, 6'b000000};
        tbl[12] = '{16'h0001, 1'b0, 1'b1, 6'b000000};
        tbl[13] = '{16'h0001, 1'b0, 1'b1, 6'b000001};
        tbl[14] = '{16'h00C0, 1'b0, 1'b1, 6'b000001};
        tbl[15] = '{16'h1081, 1'b0, 1'b0, 6'b000001};
        tbl[16] = '{16'h0090, 1'b0, 1'b1, 6'b000000};
        tbl[17] = '{16'h0090, 1'b0, 1'b1, 6'b011000};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset pad_latch", pad_latch, 0);
        check("reset pad_clk", pad_clk, 1);
        check("reset busy", busy, 0);
        check("reset valid", valid, 0);
        check("reset buttons", btn, 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset in HIGH at bit 7 aborts the frame.
        ctrl_pat = 16'h0100;
        pulse_start();
        rises = 0;
        prev_clk = pad_clk;
        for (int n = 0; n < 200 && rises < 7; n++) begin
            @(negedge clk);
            if (pad_clk && !prev_clk) rises++;
            prev_clk = pad_clk;
        end
        check("abort reached bit 7", rises, 7);
        check("abort busy before reset", busy, 1);
        reset = 1'b1;
        #1;
        check("abort pad_clk", pad_clk, 1);
        check("abort pad_latch", pad_latch, 0);
        check("abort busy", busy, 0);
        check("abort valid", valid, 0);
        vseen = 0;
        repeat (3) begin @(negedge clk); if (valid) vseen++; end
        reset = 1'b0;
        repeat (FRAME) begin @(negedge clk); if (valid) vseen++; end
        check("abort no valid", vseen, 0);
        check("abort idle busy", busy, 0);
        run_frame(16'h0100, 1'b0, 1'b1, 6'b000000, "after abort");

        // Start in the DONE cycle is dropped; start in the following IDLE cycle runs.
        do_reset();
        ctrl_pat = 16'h0000;
        pulse_start();
        wait_valid(n_at);
        check("done-start first latency", n_at, FRAME);
        check("done cycle busy", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start in DONE ignored", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start in IDLE accepted", busy, 1);
        wait_valid(n_at);
        check("idle-start latency", n_at, FRAME);

        do_reset();
        for (int i = 0; i < 18; i++)
            run_frame(tbl[i].pat, tbl[i].extra, tbl[i].v, tbl[i].btn, $sformatf("tbl%0d", i));

        do_reset();
        m_hist = '0;
        m_out  = '0;
        prev_p = 16'h0000;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                p = 16'($urandom);
                if ($urandom_range(0, 3) != 0) p[15:12] = 4'h0;
            end else begin
                p = prev_p;
            end
            prev_p = p;
            model_frame(p, ev);
            run_frame(p, $urandom_range(0, 3) == 0, ev, m_out, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
